logic_operand_loader: RTL and testbench
=======================================

Name: logic_operand_loader

Overview:
- Upstream stage of the 64-bit logic unit: assembles two 64-bit operands and a 3-bit operation select from a 32-bit write stream.
- Presents the operands, stable, to the logic unit's in_0/in_1/sel inputs with a valid/ready handshake.
- Provides the only registered boundary in front of the combinational logic unit.

Parameters:
- DATA_W, 64, operand width driven to the logic unit.
- WORD_W, 32, write-stream word width; DATA_W must equal 2*WORD_W.
- SEL_W, 3, operation select width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_valid  input  1  upstream word valid.
- wr_ready  output  1  loader can accept a word.
- wr_data  input  WORD_W  operand word.
- wr_sel  input  SEL_W  operation select; sampled only with word 0.
- out_valid  output  1  op_0/op_1/op_sel hold a complete operation.
- out_ready  input  1  downstream consumes the operation.
- op_0  output  DATA_W  to logic unit in_0.
- op_1  output  DATA_W  to logic unit in_1.
- op_sel  output  SEL_W  to logic unit sel.
- busy  output  1  high when state is not W0 (partial load or pending result).

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is W0; shadow registers, op_0, op_1, op_sel = 0; out_valid = 0; busy = 0.
  - wr_ready is gated low while rst_n is low.
- States: W0, W1, W2, W3, OUT.
  - wr_ready = 1 in W0..W3 and 0 in OUT.
- A word transfer occurs on a clock edge with wr_valid && wr_ready. States advance only on a transfer; wr_valid low holds the state and registers.
- Word order (big-half first):
  - W0: wr_data -> shadow_0[63:32]; wr_sel -> shadow_sel.
  - W1: wr_data -> shadow_0[31:0].
  - W2: wr_data -> shadow_1[63:32].
  - W3: wr_data -> shadow_1[31:0]. On the same edge, the full shadow contents (including this word) are copied to op_0/op_1/op_sel, out_valid is set to 1, and the state moves to OUT.
- Latency: out_valid rises the cycle after the 4th transfer. The minimum period is 5 cycles per operation when out_ready = 1.
- OUT:
  - op_0, op_1, op_sel and out_valid hold stable until out_valid && out_ready on an edge.
  - On that edge: out_valid = 0, state = W0.
  - op_* keep their last values after consumption and change only on the next W3 transfer.
- wr_valid asserted while in OUT: ignored, no transfer (wr_ready = 0). The upstream holds wr_data.
- out_ready while out_valid = 0: no effect.
- Reset mid-load or in OUT: partial shadow contents are discarded and all outputs return to reset values immediately.
- No arithmetic is performed; widths are passed through exactly, with no sign or zero extension.

Optional Feature:
- Macro: LOADER_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - If abort is high on an edge in W1..W3, the state returns to W0, shadow registers are cleared, and any concurrent word transfer is discarded.
  - In OUT, abort is ignored; the completed operation still waits for out_ready.
  - In W0, abort has no effect, and a concurrent W0 transfer is discarded.
- Not defined: the abort port is absent; a partial load can only be cleared by rst_n.

Test Plan:
- Basic load: words 0x89ABCDEF, 0x01234567, 0xFFFFFFFF, 0x00000000 with sel = 5 on word 0, out_ready = 1 -> the cycle after the 4th transfer, out_valid = 1, op_0 = 0x89ABCDEF01234567, op_1 = 0xFFFFFFFF00000000, op_sel = 5. out_valid clears next edge.
- Backpressure: complete a load with out_ready = 0 for 6 cycles and wr_valid held high with 0xDEADBEEF -> wr_ready = 0 and op_* stable for all 6 cycles. Raising out_ready gives one consume, then 0xDEADBEEF is accepted as word 0.
- Sel sampling: wr_sel = 2 on word 0 and 7 on words 1-3 -> op_sel = 2.
- Bubbles: wr_valid toggling 1,0,0,1,0,1,1 -> exactly 4 transfers, correct word placement, busy = 1 from the first transfer until consume.
- Async reset: assert rst_n low between clock edges after 2 words -> out_valid = 0, op_* = 0 and wr_ready = 0 immediately. After release, a new 4-word load yields the correct result with no stale data.
- LOADER_ABORT_EN: abort after 3 words -> state W0, busy = 0. The next 4 words 1, 2, 3, 4 give op_0 = 0x0000000100000002 and op_1 = 0x0000000300000004.

Source files
------------

// File: rtl/logic_operand_loader.sv
// logic_operand_loader
//   Front-end register stage for the 64-bit combinational logic unit.
//   Collects four WORD_W-bit words (big half of operand 0 first) plus an
//   operation select from a valid/ready write stream. It then presents the
//   complete operation, held stable, on op_0/op_1/op_sel under a
//   valid/ready handshake.
//
//   Optional feature macro: LOADER_ABORT_EN (adds the abort input).
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   wr_valid   upstream word valid
//   wr_ready   loader can accept a word (low in OUT and during reset)
//   wr_data    operand word
//   wr_sel     operation select, sampled with word 0 only
//   abort      (LOADER_ABORT_EN only) discard a partial load
//   out_valid  op_0/op_1/op_sel hold a complete operation
//   out_ready  downstream consumes the operation
//   op_0       to logic unit in_0
//   op_1       to logic unit in_1
//   op_sel     to logic unit sel
//   busy       state is not W0 (partial load or pending result)
module logic_operand_loader #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned WORD_W = 32,
   parameter int unsigned SEL_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef LOADER_ABORT_EN
   input  logic              abort,
`endif
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [SEL_W-1:0]  wr_sel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] op_0,
   output logic [DATA_W-1:0] op_1,
   output logic [SEL_W-1:0]  op_sel,
   output logic              busy
);

   typedef enum logic [2:0] {
      W0  = 3'd0,
      W1  = 3'd1,
      W2  = 3'd2,
      W3  = 3'd3,
      OUT = 3'd4
   } state_t;

   state_t state;
   state_t state_nxt;

   // Only the upper half of operand 1 needs a shadow: the lower half is
   // taken straight from wr_data on the W3 edge.
   logic [DATA_W-1:0] shadow_0;
   logic [WORD_W-1:0] shadow_1_hi;
   logic [SEL_W-1:0]  shadow_sel;

   logic abort_in;
   logic abort_hit;
   logic xfer;
   logic consume;

`ifdef LOADER_ABORT_EN
   assign abort_in = abort;
`else
   assign abort_in = 1'b0;
`endif

   // State resets to W0 asynchronously, so wr_ready is additionally gated
   // by rst_n to stay low for the whole reset assertion.
   assign wr_ready  = rst_n && (state != OUT);
   assign out_valid = (state == OUT);
   assign busy      = (state != W0);

   // An abort discards any word offered on the same edge, including in W0.
   assign xfer      = wr_valid && wr_ready && !abort_in;
   assign abort_hit = abort_in && (state == W1 || state == W2 || state == W3);
   assign consume   = out_valid && out_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         W0:      if (xfer)    state_nxt = W1;
         W1:      if (xfer)    state_nxt = W2;
         W2:      if (xfer)    state_nxt = W3;
         W3:      if (xfer)    state_nxt = OUT;
         OUT:     if (consume) state_nxt = W0;
         default:              state_nxt = W0;
      endcase
      if (abort_hit) state_nxt = W0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= W0;
         shadow_0    <= '0;
         shadow_1_hi <= '0;
         shadow_sel  <= '0;
         op_0        <= '0;
         op_1        <= '0;
         op_sel      <= '0;
      end else begin
         state <= state_nxt;
         if (abort_hit) begin
            shadow_0    <= '0;
            shadow_1_hi <= '0;
            shadow_sel  <= '0;
         end else if (xfer) begin
            case (state)
               W0: begin
                  shadow_0[DATA_W-1:WORD_W] <= wr_data;
                  shadow_sel                <= wr_sel;
               end
               W1: shadow_0[WORD_W-1:0] <= wr_data;
               W2: shadow_1_hi          <= wr_data;
               W3: begin
                  op_0   <= shadow_0;
                  op_1   <= {shadow_1_hi, wr_data};
                  op_sel <= shadow_sel;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_logic_operand_loader.sv
module tb_logic_operand_loader;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned SEL_W  = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_valid;
   logic              wr_ready;
   logic [WORD_W-1:0] wr_data;
   logic [SEL_W-1:0]  wr_sel;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] op_0;
   logic [DATA_W-1:0] op_1;
   logic [SEL_W-1:0]  op_sel;
   logic              busy;
`ifdef LOADER_ABORT_EN
   logic              abort;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [DATA_W-1:0] o0;
      logic [DATA_W-1:0] o1;
      logic [SEL_W-1:0]  s;
   } op_t;

   op_t sb[$];

   logic_operand_loader #(
      .DATA_W(DATA_W),
      .WORD_W(WORD_W),
      .SEL_W (SEL_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef LOADER_ABORT_EN
      .abort    (abort),
`endif
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_data  (wr_data),
      .wr_sel   (wr_sel),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .op_0     (op_0),
      .op_1     (op_1),
      .op_sel   (op_sel),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Inputs are driven just after posedge, outputs sampled at negedge.
   // A consume happens on the next posedge when out_valid && out_ready here.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_op", 1, 0);
         end else begin
            op_t e;
            e = sb.pop_front();
            check("op_0", op_0, e.o0);
            check("op_1", op_1, e.o1);
            check("op_sel", op_sel, e.s);
         end
      end
   end

   // Offer one word and return at posedge+1 after it has been transferred.
   task automatic send_word(input logic [WORD_W-1:0] d, input logic [SEL_W-1:0] s);
      int n;
      n = 0;
      wr_valid = 1'b1;
      wr_data  = d;
      wr_sel   = s;
      forever begin
         @(negedge clk);
         if (wr_ready) break;
         n++;
         if (n > 50) begin
            check("wr_ready_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic load_op(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                          input logic [WORD_W-1:0] w2, input logic [WORD_W-1:0] w3,
                          input logic [SEL_W-1:0] s0, input logic [SEL_W-1:0] s_rest);
      op_t e;
      send_word(w0, s0);
      send_word(w1, s_rest);
      send_word(w2, s_rest);
      e.o0 = {w0, w1};
      e.o1 = {w2, w3};
      e.s  = s0;
      sb.push_back(e);
      send_word(w3, s_rest);
   endtask

   logic [WORD_W-1:0] bw [4];
   logic              bpat [7];

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      op_t e;
      int  k;
      rst_n     = 1'b0;
      wr_valid  = 1'b0;
      wr_data   = '0;
      wr_sel    = '0;
      out_ready = 1'b0;
`ifdef LOADER_ABORT_EN
      abort     = 1'b0;
`endif
      // Reset state
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_op_0", op_0, 0);
      check("rst_op_1", op_1, 0);
      check("rst_op_sel", op_sel, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_ready", wr_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_wr_ready", wr_ready, 1);

      // Basic load
      out_ready = 1'b1;
      load_op(32'h89ABCDEF, 32'h01234567, 32'hFFFFFFFF, 32'h00000000, 3'd5, 3'd5);
      check("basic_latency_valid", out_valid, 1);
      check("basic_busy_pending", busy, 1);
      @(posedge clk);
      #1;
      check("basic_valid_clear", out_valid, 0);
      check("basic_busy_clear", busy, 0);
      check("basic_op_0_held", op_0, 64'h89ABCDEF01234567);

      // Sel sampled only with word 0
      load_op(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 3'd2, 3'd7);
      @(posedge clk);
      #1;

      // Backpressure
      out_ready = 1'b0;
      load_op(32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0, 3'd3, 3'd0);
      wr_valid = 1'b1;
      wr_data  = 32'hDEADBEEF;
      wr_sel   = 3'd1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("bp_wr_ready", wr_ready, 0);
         check("bp_valid", out_valid, 1);
         check("bp_op_0", op_0, 64'hA5A5A5A55A5A5A5A);
         check("bp_op_1", op_1, 64'h0F0F0F0FF0F0F0F0);
         check("bp_op_sel", op_sel, 3'd3);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_consumed", out_valid, 0);
      check("bp_idle", busy, 0);
      check("bp_ready_again", wr_ready, 1);
      @(posedge clk);
      #1;
      check("bp_word0_taken", busy, 1);
      e.o0 = {32'hDEADBEEF, 32'h00000001};
      e.o1 = {32'h00000002, 32'h00000003};
      e.s  = 3'd1;
      send_word(32'h00000001, 3'd6);
      send_word(32'h00000002, 3'd6);
      sb.push_back(e);
      send_word(32'h00000003, 3'd6);
      @(posedge clk);
      #1;

      // Bubbles
      bw[0] = 32'hCAFEF00D; bw[1] = 32'h12345678;
      bw[2] = 32'h87654321; bw[3] = 32'h0BADC0DE;
      bpat[0] = 1; bpat[1] = 0; bpat[2] = 0; bpat[3] = 1;
      bpat[4] = 0; bpat[5] = 1; bpat[6] = 1;
      k = 0;
      for (int i = 0; i < 7; i++) begin
         wr_valid = bpat[i];
         if (bpat[i]) begin
            wr_data = bw[k];
            wr_sel  = (k == 0) ? 3'd4 : 3'd1;
         end
         @(negedge clk);
         check("bub_busy", busy, (k > 0));
         @(posedge clk);
         #1;
         if (bpat[i]) k++;
      end
      wr_valid = 1'b0;
      e.o0 = {bw[0], bw[1]};
      e.o1 = {bw[2], bw[3]};
      e.s  = 3'd4;
      sb.push_back(e);
      check("bub_transfers", k, 4);
      check("bub_valid", out_valid, 1);
      check("bub_busy_pending", busy, 1);
      @(posedge clk);
      #1;
      check("bub_busy_clear", busy, 0);

      // Async reset mid-load
      send_word(32'h77777777, 3'd7);
      send_word(32'h66666666, 3'd7);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_op_0", op_0, 0);
      check("arst_op_1", op_1, 0);
      check("arst_op_sel", op_sel, 0);
      check("arst_wr_ready", wr_ready, 0);
      check("arst_busy", busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      load_op(32'h00000010, 32'h00000020, 32'h00000030, 32'h00000040, 3'd6, 3'd0);
      @(posedge clk);
      #1;

`ifdef LOADER_ABORT_EN
      // Abort after three words, with a concurrent word offered
      send_word(32'h99999999, 3'd7);
      send_word(32'h88888888, 3'd7);
      send_word(32'h77777777, 3'd7);
      abort    = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 32'h55555555;
      @(posedge clk);
      #1;
      check("abort_busy", busy, 0);
      check("abort_valid", out_valid, 0);
      // Abort in W0 discards the offered word
      @(posedge clk);
      #1;
      check("abort_w0_busy", busy, 0);
      abort    = 1'b0;
      wr_valid = 1'b0;
      load_op(32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 3'd0, 3'd0);
      @(posedge clk);
      #1;
`endif

      repeat (4) @(posedge clk);
      #1;
      check("sb_drained", sb.size(), 0);
      check("final_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
